// File: rtl/demux4_route.sv
// demux4_route: registered 1-to-4 word demux; build with DEMUX4_ERR_CNT_EN to count discarded invalid-code words.
// Latency: 1 cycle from accept to out_valid; drain and refill in one cycle sustain 1 word/cycle.
// Backpressure: in_ready drops while the held word's sink stalls or ena is low; a stalled word is held stable.
module demux4_route #(
    parameter int WIDTH = 32,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       choice,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [31:0]      xfer_cnt,
    output logic [ERR_W-1:0] err_cnt
);

    typedef struct packed {
        logic [1:0]       sel;
        logic [WIDTH-1:0] dat;
    } hold_t;

    logic       hold_v;
    hold_t      hold_q;
    logic       code_vld;
    logic [1:0] code_sel;
    logic       drain;
    logic       accept;

    always_comb begin
        code_vld = 1'b1;
        code_sel = 2'd0;
        case (choice)
            3'd1:    code_sel = 2'd0;
            3'd2:    code_sel = 2'd1;
            3'd3:    code_sel = 2'd2;
            3'd4:    code_sel = 2'd3;
            default: code_vld = 1'b0;
        endcase
    end

    assign drain    = hold_v & out_ready[hold_q.sel];
    // rst_n term keeps in_ready low for the whole reset pulse, not just after the first edge
    assign in_ready = rst_n & ena & (~hold_v | drain);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (accept && code_vld) begin
            hold_v     <= 1'b1;
            hold_q.sel <= code_sel;
            hold_q.dat <= in_data;
        end else if (drain) begin
            hold_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xfer_cnt <= 32'd0;
        else if (drain)
            xfer_cnt <= xfer_cnt + 32'd1;
    end

`ifdef DEMUX4_ERR_CNT_EN
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (accept && !code_vld && err_cnt != '1)
            err_cnt <= err_cnt + ERR_ONE;
    end
`else
    assign err_cnt = '0;
`endif

    always_comb begin
        out_valid = 4'b0000;
        if (hold_v)
            out_valid[hold_q.sel] = 1'b1;
    end

    // Unselected sinks see zero rather than the stale payload
    assign out1 = out_valid[0] ? hold_q.dat : '0;
    assign out2 = out_valid[1] ? hold_q.dat : '0;
    assign out3 = out_valid[2] ? hold_q.dat : '0;
    assign out4 = out_valid[3] ? hold_q.dat : '0;

endmodule

// File: tb/tb_demux4_route.sv
// tb_demux4_route: scoreboard bench for demux4_route; expected words queued on accept, checked as sinks see them.
module tb_demux4_route;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  choice;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out1, out2, out3, out4;
    logic [31:0] xfer_cnt;
    logic [7:0]  err_cnt;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   drained;
    int   exp_err;
    bit   rand_rdy;
    int   w;

    demux4_route #(.WIDTH(32), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready),
        .choice(choice), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] err_exp();
`ifdef DEMUX4_ERR_CNT_EN
        return 8'(exp_err);
`else
        return 8'd0;
`endif
    endfunction

    // Sink-side monitor: every cycle with a valid output must match the oldest expected word
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] got;
        logic [31:0] others;
        if (rst_n) begin
            if (out_valid != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious", {60'd0, out_valid}, 64'd0);
                end else begin
                    e = sb[0];
                    chk("sb_vld", {60'd0, out_valid}, {60'd0, 4'b0001 << e.sel});
                    case (e.sel)
                        2'd0: got = out1;
                        2'd1: got = out2;
                        2'd2: got = out3;
                        default: got = out4;
                    endcase
                    chk("sb_dat", {32'd0, got}, {32'd0, e.dat});
                    others = ((e.sel != 2'd0) ? out1 : 32'd0) | ((e.sel != 2'd1) ? out2 : 32'd0) |
                             ((e.sel != 2'd2) ? out3 : 32'd0) | ((e.sel != 2'd3) ? out4 : 32'd0);
                    chk("sb_others_zero", {32'd0, others}, 64'd0);
                    if (out_ready[e.sel]) begin
                        void'(sb.pop_front());
                        drained++;
                    end
                end
            end else begin
                chk("idle_zero", {32'd0, out1 | out2 | out3 | out4}, 64'd0);
            end
        end
    end

    // Offer one word and hold it until taken; returns the number of cycles it waited
    task automatic offer(input logic [2:0] c, input logic [31:0] d, output int waits);
        logic [2:0] s;
        bit         to;
        exp_t       e;
        in_valid = 1'b1;
        choice   = c;
        in_data  = d;
        waits    = 0;
        to       = 1'b0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits >= 50) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 4'($urandom);
        end
        chk("offer_timeout", {63'd0, to}, 64'd0);
        if (!to) begin
            if (c >= 3'd1 && c <= 3'd4) begin
                s     = c - 3'd1;
                e.sel = s[1:0];
                e.dat = d;
                sb.push_back(e);
            end else if (exp_err < 255) begin
                exp_err++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] inv_codes [4];
        inv_codes[0] = 3'd0; inv_codes[1] = 3'd5; inv_codes[2] = 3'd6; inv_codes[3] = 3'd7;
        n_cmp = 0; n_bad = 0; drained = 0; exp_err = 0; rand_rdy = 1'b0;
        rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; choice = 3'd0; in_data = 32'd0; out_ready = 4'b0000;

        // Reset values
        #12;
        ena = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
        chk("rst_outs", {32'd0, out1 | out2 | out3 | out4}, 64'd0);
        chk("rst_xfer", {32'd0, xfer_cnt}, 64'd0);
        chk("rst_err", {56'd0, err_cnt}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word to sink 2
        out_ready = 4'b1111;
        offer(3'd2, 32'hDEADBEEF, w);
        in_valid = 1'b0;
        chk("t1_wait", w, 0);
        chk("t1_vld", {60'd0, out_valid}, 64'b0010);
        chk("t1_out2", {32'd0, out2}, 64'hDEADBEEF);
        chk("t1_out134", {32'd0, out1 | out3 | out4}, 64'd0);
        @(posedge clk); #1;
        chk("t1_xfer", {32'd0, xfer_cnt}, 64'd1);

        // Back-to-back to every sink
        for (int i = 1; i <= 4; i++) begin
            offer(3'(i), 32'(i * 17), w);
            chk("b2b_no_wait", w, 0);
        end
        idle_cycles(2);
        chk("b2b_xfer", {32'd0, xfer_cnt}, 64'd5);
        chk("b2b_empty", sb.size(), 0);

        // Stall sink 3, second word must wait, then drain and refill in one edge
        out_ready = 4'b1011;
        offer(3'd3, 32'hA5A5A5A5, w);
        in_valid = 1'b1; choice = 3'd1; in_data = 32'h0000_0077;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out3", {32'd0, out3}, 64'hA5A5A5A5);
            chk("stall_vld", {60'd0, out_valid}, 64'b0100);
            @(posedge clk); #1;
        end
        out_ready = 4'b1111;
        offer(3'd1, 32'h0000_0077, w);
        chk("stall_same_cycle", w, 0);
        chk("stall_refill_vld", {60'd0, out_valid}, 64'b0001);
        chk("stall_xfer", {32'd0, xfer_cnt}, 64'(drained));
        idle_cycles(2);

        // Invalid codes are consumed; counter saturates
        offer(3'd0, 32'h1234_5678, w);
        offer(3'd7, 32'h8765_4321, w);
        idle_cycles(1);
        chk("inv_vld", {60'd0, out_valid}, 64'd0);
        chk("inv_err2", {56'd0, err_cnt}, {56'd0, err_exp()});
        for (int i = 0; i < 298; i++) offer(inv_codes[i % 4], 32'(i), w);
        idle_cycles(1);
        chk("inv_err_sat", {56'd0, err_cnt}, {56'd0, err_exp()});
        chk("inv_empty", sb.size(), 0);

        // ena low: held word drains, no new accepts
        out_ready = 4'b0000;
        offer(3'd4, 32'h4444_0000, w);
        ena = 1'b0; out_ready = 4'b1111;
        in_valid = 1'b1; choice = 3'd1; in_data = 32'h55;
        @(negedge clk);
        chk("ena_in_ready0", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("ena_drained", {60'd0, out_valid}, 64'd0);
        chk("ena_xfer", {32'd0, xfer_cnt}, 64'(drained));
        @(negedge clk);
        chk("ena_in_ready1", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        ena = 1'b1;
        offer(3'd1, 32'h55, w);
        chk("ena_resume", w, 0);
        idle_cycles(2);

        // Random mix with random sink readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            out_ready = 4'($urandom);
            offer(3'($urandom_range(0, 7)), $urandom, w);
        end
        rand_rdy = 1'b0;
        out_ready = 4'b1111;
        idle_cycles(3);
        chk("rnd_empty", sb.size(), 0);
        chk("rnd_xfer", {32'd0, xfer_cnt}, 64'(drained));
        chk("rnd_err", {56'd0, err_cnt}, {56'd0, err_exp()});

        // Asynchronous reset while sink 3 holds a word
        out_ready = 4'b0000;
        offer(3'd3, 32'hCAFE_F00D, w);
        in_valid = 1'b0;
        chk("ar_pre_vld", {60'd0, out_valid}, 64'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", {60'd0, out_valid}, 64'd0);
        chk("ar_out3", {32'd0, out3}, 64'd0);
        chk("ar_xfer", {32'd0, xfer_cnt}, 64'd0);
        chk("ar_err", {56'd0, err_cnt}, 64'd0);
        chk("ar_in_ready", {63'd0, in_ready}, 64'd0);
        sb.delete();
        drained = 0;
        exp_err = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 4'b1111;
        offer(3'd4, 32'h0BAD_CAFE, w);
        idle_cycles(2);
        chk("post_rst_xfer", {32'd0, xfer_cnt}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
